// File: rtl/decoder_onehot_monitor.sv
// -----------------------------------------------------------------------------
// decoder_onehot_monitor
//
// Purpose: watches the eight one-hot outputs of a 3-to-8 decoder, checks that
// exactly one line is high, re-encodes the hot line to a 3-bit code and flags
// code changes and no-hot / multi-hot faults. Optional per-line hit counters
// with a registered readback port.
//
// Pipeline: edge N captures d0..d7 (stage 1), edge N+1 classifies the sample
// (stage 2), edge N+2 drives the registered result pulses and the FSM.
//
// Optional feature macro: DECODER_MON_HIT_CNT_EN
//   defined   -> eight HIT_W-bit saturating hit counters + rd_cnt readback mux
//   undefined -> no counters, rd_cnt tied to 0, rd_sel ignored
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   d0..d7      in   decoder outputs, d0 is index 0
//   sample_en   in   capture d0..d7 this cycle
//   clr         in   synchronous clear of fault, history, counters, pipeline
//   rd_sel      in   counter index for readback
//   code        out  encoded index of the hot line (holds on errors)
//   code_valid  out  one-cycle pulse, code is valid
//   change      out  one-cycle pulse with code_valid when the code is new
//   err_none    out  one-cycle pulse, sample had no line high
//   err_multi   out  one-cycle pulse, sample had two or more lines high
//   fault       out  level, high while the FSM is in FAULT
//   rd_cnt      out  registered readback of hit_cnt[rd_sel]
// -----------------------------------------------------------------------------
module decoder_onehot_monitor #(
   parameter int HIT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             d0,
   input  logic             d1,
   input  logic             d2,
   input  logic             d3,
   input  logic             d4,
   input  logic             d5,
   input  logic             d6,
   input  logic             d7,
   input  logic             sample_en,
   input  logic             clr,
   input  logic [2:0]       rd_sel,
   output logic [2:0]       code,
   output logic             code_valid,
   output logic             change,
   output logic             err_none,
   output logic             err_multi,
   output logic             fault,
   output logic [HIT_W-1:0] rd_cnt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FAULT = 2'd2;

   // sample classes carried from stage 2 to the output stage
   localparam logic [1:0] C_NONE  = 2'd0;
   localparam logic [1:0] C_ONE   = 2'd1;
   localparam logic [1:0] C_MULTI = 2'd2;

   logic [7:0] w_vec;
   assign w_vec = {d7, d6, d5, d4, d3, d2, d1, d0};

   // stage 1
   logic [7:0] r_vec_q;
   logic       r_s1_v;

   // stage 2
   logic       r_s2_v;
   logic [1:0] r_s2_cls;
   logic [2:0] r_s2_idx;

   // output stage / FSM
   logic [1:0] r_state;
   logic [2:0] r_code;
   logic       r_code_valid;
   logic       r_change;
   logic       r_err_none;
   logic       r_err_multi;
   logic [2:0] r_last_code;
   logic       r_have_last;

   // popcount and hot index of the captured vector; the index is only
   // meaningful when the popcount is exactly one
   logic [3:0] w_pop;
   logic [2:0] w_idx;
   logic [1:0] w_cls;

   always_comb begin
      w_pop = 4'd0;
      w_idx = 3'd0;
      w_cls = C_NONE;
      for (int i = 0; i < 8; i++) begin
         w_pop = w_pop + {3'd0, r_vec_q[i]};
         if (r_vec_q[i]) begin
            w_idx = 3'(i);
         end
      end
      if (w_pop == 4'd0) begin
         w_cls = C_NONE;
      end else if (w_pop == 4'd1) begin
         w_cls = C_ONE;
      end else begin
         w_cls = C_MULTI;
      end
   end

   logic w_s2_one;
   logic w_s2_none;
   logic w_s2_multi;

   assign w_s2_one   = r_s2_v && (r_s2_cls == C_ONE);
   assign w_s2_none  = r_s2_v && (r_s2_cls == C_NONE);
   assign w_s2_multi = r_s2_v && (r_s2_cls == C_MULTI);

   // capture and classification pipeline; clr drops anything in flight,
   // including a sample_en presented in the same cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vec_q  <= 8'd0;
         r_s1_v   <= 1'b0;
         r_s2_v   <= 1'b0;
         r_s2_cls <= C_NONE;
         r_s2_idx <= 3'd0;
      end else if (clr) begin
         r_s1_v <= 1'b0;
         r_s2_v <= 1'b0;
      end else begin
         r_s1_v <= sample_en;
         if (sample_en) begin
            r_vec_q <= w_vec;
         end
         r_s2_v <= r_s1_v;
         if (r_s1_v) begin
            r_s2_cls <= w_cls;
            r_s2_idx <= w_idx;
         end
      end
   end

   // result pulses, change history and FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_code       <= 3'd0;
         r_code_valid <= 1'b0;
         r_change     <= 1'b0;
         r_err_none   <= 1'b0;
         r_err_multi  <= 1'b0;
         r_last_code  <= 3'd0;
         r_have_last  <= 1'b0;
      end else begin
         r_code_valid <= 1'b0;
         r_change     <= 1'b0;
         r_err_none   <= 1'b0;
         r_err_multi  <= 1'b0;
         if (clr) begin
            r_state     <= S_IDLE;
            r_last_code <= 3'd0;
            r_have_last <= 1'b0;
         end else if (w_s2_one) begin
            r_code       <= r_s2_idx;
            r_code_valid <= 1'b1;
            r_change     <= !r_have_last || (r_s2_idx != r_last_code);
            r_last_code  <= r_s2_idx;
            r_have_last  <= 1'b1;
            // a valid sample never leaves FAULT; only clr does
            if (r_state == S_IDLE) begin
               r_state <= S_RUN;
            end
         end else if (w_s2_none) begin
            r_err_none <= 1'b1;
            r_state    <= S_FAULT;
         end else if (w_s2_multi) begin
            r_err_multi <= 1'b1;
            r_state     <= S_FAULT;
         end
      end
   end

   assign code       = r_code;
   assign code_valid = r_code_valid;
   assign change     = r_change;
   assign err_none   = r_err_none;
   assign err_multi  = r_err_multi;
   assign fault      = (r_state == S_FAULT);

`ifdef DECODER_MON_HIT_CNT_EN
   logic [HIT_W-1:0] r_hit_cnt [8];
   logic [HIT_W-1:0] r_rd_cnt;
   logic             w_cnt_en;

   // counters are frozen while in FAULT, but the sample still reports a code
   assign w_cnt_en = w_s2_one && (r_state != S_FAULT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            r_hit_cnt[i] <= '0;
         end
         r_rd_cnt <= '0;
      end else begin
         // readback shows the value before any increment on this edge
         r_rd_cnt <= r_hit_cnt[rd_sel];
         if (clr) begin
            for (int i = 0; i < 8; i++) begin
               r_hit_cnt[i] <= '0;
            end
         end else if (w_cnt_en && (r_hit_cnt[r_s2_idx] != {HIT_W{1'b1}})) begin
            r_hit_cnt[r_s2_idx] <= r_hit_cnt[r_s2_idx] + HIT_W'(1);
         end
      end
   end

   assign rd_cnt = r_rd_cnt;
`else
   logic w_unused_rd_sel;
   assign w_unused_rd_sel = ^rd_sel;
   assign rd_cnt          = '0;
`endif

endmodule

// File: tb/tb_decoder_onehot_monitor.sv
module tb_decoder_onehot_monitor;

`ifdef DECODER_MON_HIT_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic [7:0] d_vec;
   logic       sample_en;
   logic       clr;
   logic [2:0] rd_sel;

   logic [2:0] code;
   logic       code_valid, change, err_none, err_multi, fault;
   logic [7:0] rd_cnt;

   logic [2:0] s_code;
   logic       s_code_valid, s_change, s_err_none, s_err_multi, s_fault;
   logic [1:0] s_rd_cnt;

   int checks = 0;
   int errors = 0;

   decoder_onehot_monitor #(.HIT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .d0(d_vec[0]), .d1(d_vec[1]), .d2(d_vec[2]), .d3(d_vec[3]),
      .d4(d_vec[4]), .d5(d_vec[5]), .d6(d_vec[6]), .d7(d_vec[7]),
      .sample_en(sample_en), .clr(clr), .rd_sel(rd_sel),
      .code(code), .code_valid(code_valid), .change(change),
      .err_none(err_none), .err_multi(err_multi), .fault(fault),
      .rd_cnt(rd_cnt)
   );

   // narrow-counter instance fed the same stimulus, used for saturation
   decoder_onehot_monitor #(.HIT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n),
      .d0(d_vec[0]), .d1(d_vec[1]), .d2(d_vec[2]), .d3(d_vec[3]),
      .d4(d_vec[4]), .d5(d_vec[5]), .d6(d_vec[6]), .d7(d_vec[7]),
      .sample_en(sample_en), .clr(clr), .rd_sel(rd_sel),
      .code(s_code), .code_valid(s_code_valid), .change(s_change),
      .err_none(s_err_none), .err_multi(s_err_multi), .fault(s_fault),
      .rd_cnt(s_rd_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // in-flight samples: slot 0 captured last edge, slot 1 reported next edge
   bit         p_v   [2];
   logic [7:0] p_vec [2];
   bit         m_fault;
   int         m_last;      // -1 means no valid code since reset/clr
   int         m_hits [8];  // unsaturated hit totals

   logic [2:0] e_code;
   logic       e_cv, e_ch, e_en, e_em, e_fault;
   logic [7:0] e_rd8;
   logic [1:0] e_rd2;

   function automatic int sat(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return CNT_EN ? ((v > mx) ? mx : v) : 0;
   endfunction

   task automatic m_reset();
      p_v[0] = 0; p_v[1] = 0;
      m_fault = 0; m_last = -1;
      for (int i = 0; i < 8; i++) m_hits[i] = 0;
      e_code = 3'd0; e_cv = 0; e_ch = 0; e_en = 0; e_em = 0; e_fault = 0;
      e_rd8 = 8'd0; e_rd2 = 2'd0;
   endtask

   task automatic drive(input logic [7:0] v, input logic se, input logic c, input logic [2:0] sel);
      d_vec = v; sample_en = se; clr = c; rd_sel = sel;
   endtask

   // advance one clock, update the model, leave time at edge + 1
   task automatic tick();
      bit         out_v;
      logic [7:0] out_vec;
      int         n, idx;
      @(posedge clk);
      if (!rst_n) begin
         m_reset();
      end else begin
         e_rd8 = 8'(sat(m_hits[rd_sel], 8));
         e_rd2 = 2'(sat(m_hits[rd_sel], 2));
         e_cv = 0; e_ch = 0; e_en = 0; e_em = 0;
         if (clr) begin
            m_fault = 0; m_last = -1;
            for (int i = 0; i < 8; i++) m_hits[i] = 0;
            p_v[0] = 0; p_v[1] = 0;
         end else begin
            out_v = p_v[1]; out_vec = p_vec[1];
            p_v[1] = p_v[0]; p_vec[1] = p_vec[0];
            p_v[0] = sample_en; p_vec[0] = d_vec;
            if (out_v) begin
               n = $countones(out_vec);
               if (n == 1) begin
                  idx = 0;
                  for (int i = 0; i < 8; i++) if (out_vec[i]) idx = i;
                  e_code = 3'(idx);
                  e_cv = 1;
                  e_ch = (idx != m_last);
                  m_last = idx;
                  if (!m_fault) m_hits[idx]++;
               end else if (n == 0) begin
                  e_en = 1; m_fault = 1;
               end else begin
                  e_em = 1; m_fault = 1;
               end
            end
         end
         e_fault = m_fault;
      end
      #1;
   endtask

   function automatic logic [7:0] obs_bus();
      return {code, code_valid, change, err_none, err_multi, fault};
   endfunction

   function automatic logic [7:0] exp_bus();
      return {e_code, e_cv, e_ch, e_en, e_em, e_fault};
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      drive(8'h00, 0, 0, 3'd0);
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({obs_bus(), rd_cnt, s_rd_cnt} !== 18'd0)
         begin errors++; $display("FAIL reset_outputs act=%h exp=0", {obs_bus(), rd_cnt, s_rd_cnt}); end
      rst_n = 1'b1;
      tick();
      checks++;
      if (obs_bus() !== exp_bus())
         begin errors++; $display("FAIL reset_release act=%h exp=%h", obs_bus(), exp_bus()); end
   endtask

   task automatic test_sweep();
      for (int k = 0; k < 10; k++) begin
         if (k < 8) drive(8'(1 << k), 1, 0, 3'(k));
         else       drive(8'h00, 0, 0, 3'd0);
         tick();
         checks++;
         if (obs_bus() !== exp_bus())
            begin errors++; $display("FAIL sweep_bus k=%0d act=%h exp=%h", k, obs_bus(), exp_bus()); end
         if (k >= 2) begin
            checks++;
            if (code !== 3'(k - 2) || code_valid !== 1'b1 || change !== 1'b1 || fault !== 1'b0)
               begin errors++; $display("FAIL sweep_code k=%0d act code=%0d cv=%b ch=%b f=%b exp code=%0d cv=1 ch=1 f=0",
                                        k, code, code_valid, change, fault, k - 2); end
         end
      end
      for (int s = 0; s < 8; s++) begin
         drive(8'h00, 0, 0, 3'(s));
         tick();
         checks++;
         if (rd_cnt !== e_rd8 || rd_cnt !== 8'(CNT_EN ? 1 : 0))
            begin errors++; $display("FAIL sweep_rdcnt sel=%0d act=%0d exp=%0d", s, rd_cnt, e_rd8); end
      end
   endtask

   task automatic test_repeat();
      int ncv = 0, nch = 0;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive(8'h20, 1, 0, 3'd5);
         else       drive(8'h00, 0, 0, 3'd5);
         tick();
         checks++;
         if (obs_bus() !== exp_bus())
            begin errors++; $display("FAIL repeat_bus i=%0d act=%h exp=%h", i, obs_bus(), exp_bus()); end
         ncv += int'(code_valid);
         nch += int'(change);
      end
      checks++;
      if (ncv != 4 || nch != 1)
         begin errors++; $display("FAIL repeat_pulses act cv=%0d ch=%0d exp cv=4 ch=1", ncv, nch); end
      tick();
      checks++;
      if (rd_cnt !== e_rd8 || rd_cnt !== 8'(CNT_EN ? 5 : 0))
         begin errors++; $display("FAIL repeat_hits act=%0d exp=%0d", rd_cnt, e_rd8); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 8; i++) begin
         if (i < 6) drive(8'h02, 1, 0, 3'd1);
         else       drive(8'h00, 0, 0, 3'd1);
         tick();
      end
      tick();
      checks++;
      if (s_rd_cnt !== e_rd2 || s_rd_cnt !== 2'(CNT_EN ? 3 : 0))
         begin errors++; $display("FAIL sat_narrow act=%0d exp=%0d", s_rd_cnt, e_rd2); end
      checks++;
      if (rd_cnt !== e_rd8 || rd_cnt !== 8'(CNT_EN ? 7 : 0))
         begin errors++; $display("FAIL sat_wide act=%0d exp=%0d", rd_cnt, e_rd8); end
   endtask

   task automatic test_clr_inflight();
      drive(8'h10, 1, 0, 3'd4);
      tick();
      drive(8'h00, 1, 1, 3'd4);   // sample_en in the clr cycle is dropped too
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(8'h00, 0, 0, 3'd4);
         tick();
         checks++;
         if (code_valid !== 1'b0 || fault !== 1'b0 || obs_bus() !== exp_bus())
            begin errors++; $display("FAIL clr_pulse i=%0d act=%h exp=%h", i, obs_bus(), exp_bus()); end
      end
      for (int s = 0; s < 8; s++) begin
         drive(8'h00, 0, 0, 3'(s));
         tick();
         checks++;
         if (rd_cnt !== 8'd0 || s_rd_cnt !== 2'd0)
            begin errors++; $display("FAIL clr_counters sel=%0d act=%0d/%0d exp=0", s, rd_cnt, s_rd_cnt); end
      end
      drive(8'h10, 1, 0, 3'd0);
      tick();
      drive(8'h00, 0, 0, 3'd0);
      tick();
      tick();
      checks++;
      if (code !== 3'd4 || code_valid !== 1'b1 || change !== 1'b1)
         begin errors++; $display("FAIL clr_next_change act code=%0d cv=%b ch=%b exp code=4 cv=1 ch=1", code, code_valid, change); end
   endtask

   task automatic test_fault();
      // one clean d2 before the fault so the frozen counter is non-zero
      drive(8'h04, 1, 0, 3'd2); tick();
      drive(8'h00, 0, 0, 3'd2); tick(); tick();
      drive(8'h00, 1, 0, 3'd2); tick();
      drive(8'h00, 0, 0, 3'd2); tick(); tick();
      checks++;
      if (err_none !== 1'b1 || fault !== 1'b1 || code_valid !== 1'b0 || obs_bus() !== exp_bus())
         begin errors++; $display("FAIL fault_none act=%h exp=%h", obs_bus(), exp_bus()); end
      drive(8'h04, 1, 0, 3'd2); tick();
      drive(8'h00, 0, 0, 3'd2); tick(); tick();
      checks++;
      if (code !== 3'd2 || code_valid !== 1'b1 || fault !== 1'b1 || obs_bus() !== exp_bus())
         begin errors++; $display("FAIL fault_valid act=%h exp=%h", obs_bus(), exp_bus()); end
      tick();
      checks++;
      if (rd_cnt !== e_rd8 || rd_cnt !== 8'(CNT_EN ? 1 : 0))
         begin errors++; $display("FAIL fault_freeze act=%0d exp=%0d", rd_cnt, e_rd8); end
      drive(8'h48, 1, 0, 3'd0); tick();
      drive(8'h00, 0, 0, 3'd0); tick(); tick();
      checks++;
      if (err_multi !== 1'b1 || err_none !== 1'b0 || code_valid !== 1'b0 || fault !== 1'b1)
         begin errors++; $display("FAIL fault_multi act=%h exp=%h", obs_bus(), exp_bus()); end
      drive(8'h00, 0, 1, 3'd0); tick();
      drive(8'h00, 0, 0, 3'd0); tick();
      checks++;
      if (fault !== 1'b0 || obs_bus() !== exp_bus())
         begin errors++; $display("FAIL fault_clear act=%h exp=%h", obs_bus(), exp_bus()); end
   endtask

   task automatic test_random();
      logic [7:0] v;
      int r;
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 99);
         if (r < 65)      v = 8'(1 << $urandom_range(0, 7));
         else if (r < 78) v = 8'h00;
         else begin
            v = 8'($urandom);
            if ($countones(v) < 2) v = v | 8'h81;
         end
         drive(v, ($urandom_range(0, 9) < 8), ($urandom_range(0, 49) == 0), 3'($urandom_range(0, 7)));
         tick();
         checks++;
         if (obs_bus() !== exp_bus())
            begin errors++; $display("FAIL rand_bus i=%0d act=%h exp=%h", i, obs_bus(), exp_bus()); end
         checks++;
         if (rd_cnt !== e_rd8 || s_rd_cnt !== e_rd2)
            begin errors++; $display("FAIL rand_rdcnt i=%0d act=%0d/%0d exp=%0d/%0d", i, rd_cnt, s_rd_cnt, e_rd8, e_rd2); end
         checks++;
         if ((int'(code_valid) + int'(err_none) + int'(err_multi)) > 1)
            begin errors++; $display("FAIL rand_exclusive i=%0d act cv=%b en=%b em=%b exp at most one", i, code_valid, err_none, err_multi); end
      end
   endtask

   task automatic test_reset_mid();
      drive(8'h00, 0, 1, 3'd0); tick();   // start from a clean history
      for (int k = 0; k < 3; k++) begin
         drive(8'(1 << k), 1, 0, 3'd0);
         tick();
      end
      #2;
      rst_n = 1'b0;
      m_reset();
      #1;
      checks++;
      if ({obs_bus(), rd_cnt, s_rd_cnt} !== 18'd0)
         begin errors++; $display("FAIL rstmid_async act=%h exp=0", {obs_bus(), rd_cnt, s_rd_cnt}); end
      tick();
      rst_n = 1'b1;
      drive(8'h00, 0, 0, 3'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (obs_bus() !== 8'd0 || obs_bus() !== exp_bus())
            begin errors++; $display("FAIL rstmid_stale i=%0d act=%h exp=%h", i, obs_bus(), exp_bus()); end
      end
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_repeat();
      test_saturation();
      test_clr_inflight();
      test_fault();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout act=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
